// File: rtl/bus_ctrl_pkg.sv
// Shared types and constants for the hct74245 bus sequencer.
package bus_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TURN    = 2'd1,
      XFER    = 2'd2,
      RELEASE = 2'd3
   } state_e;

   localparam logic DIR_A2B = 1'b1;
   localparam logic DIR_B2A = 1'b0;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cycle_down_counter.sv
// Loadable down-counter with a zero flag; saturates at 0 so it never wraps.
module cycle_down_counter #(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             _reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] cnt_q;

   // Load has priority over decrement; decrement stops at 0.
   always_ff @(posedge clk) begin
      if (!_reset) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - WIDTH'(1);
      end
   end

   // Zero flag is purely a decode of the count.
   always_comb begin
      zero = (cnt_q == '0);
   end

endmodule

// File: rtl/hct245_bus_ctrl.sv
// Sequencer for one hct74245 transceiver: owns dir/nOE and the local A-side
// driver, inserting dead cycles so the two A-side drivers never overlap.
module hct245_bus_ctrl
   import bus_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned TURN_CYCLES = 1,
   parameter int unsigned XFER_CYCLES = 2,
   parameter string       NAME        = "BUSCTL",
   parameter int unsigned LOG         = 0
) (
   input  logic             clk,
   input  logic             _reset,
   input  logic             req,
   input  logic             we,
   input  logic [WIDTH-1:0] wdata,
   output logic             ack,
   output logic             busy,
   output logic [WIDTH-1:0] rdata,
   output logic             dir,
   output logic             nOE,
   output logic             a_oe,
   output logic [WIDTH-1:0] a_out,
   input  logic [WIDTH-1:0] a_in
);

   localparam int unsigned CNT_W = $clog2(max_u(TURN_CYCLES, XFER_CYCLES)) + 1;

   if (TURN_CYCLES == 0 || XFER_CYCLES == 0 || LOG > 1) begin : g_bad_param
      $error("%s: TURN_CYCLES and XFER_CYCLES must be >= 1, LOG must be 0 or 1", NAME);
   end

   state_e           state_q, state_d;
   logic             cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0] cnt_val;

   cycle_down_counter #(
      .WIDTH (CNT_W)
   ) u_cnt (
      .clk      (clk),
      ._reset   (_reset),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // Next-state and counter control.
   always_comb begin
      state_d  = state_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_val  = '0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               state_d  = TURN;
               cnt_load = 1'b1;
               cnt_val  = CNT_W'(TURN_CYCLES - 1);
            end
         end
         TURN: begin
            if (cnt_zero) begin
               state_d  = XFER;
               cnt_load = 1'b1;
               cnt_val  = CNT_W'(XFER_CYCLES - 1);
            end else begin
               cnt_dec = 1'b1;
            end
         end
         XFER: begin
            if (cnt_zero) begin
               state_d = RELEASE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!_reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request capture (dir only moves on the IDLE->TURN edge) and read-data sampling.
   always_ff @(posedge clk) begin
      if (!_reset) begin
         dir   <= DIR_B2A;
         a_out <= '0;
         rdata <= '0;
      end else begin
         if (state_q == IDLE && req) begin
            dir   <= we;
            a_out <= wdata;
         end
         if (state_q == XFER && cnt_zero && dir == DIR_B2A) begin
            rdata <= a_in;
         end
      end
   end

   // Pin decode; a_oe is gated by dir so A is never driven while the transceiver drives it.
   always_comb begin
      nOE  = (state_q != XFER);
      a_oe = ((state_q == TURN) || (state_q == XFER)) && (dir == DIR_A2B);
      ack  = (state_q == RELEASE);
      busy = (state_q != IDLE);
   end

endmodule

// File: tb/tb_hct245_bus_ctrl.sv
// Bench for hct245_bus_ctrl: default instance plus a TURN=3/XFER=1 instance,
// each wired to a behavioural hct74245 and a shared backplane driver.
module tb_hct245_bus_ctrl;

   typedef struct {
      int         which;   // 0 = default instance, 1 = TURN=3/XFER=1 instance
      logic       we;
      logic [7:0] wd;
      logic [7:0] bval;    // backplane value while the transceiver is not driving B
      logic [7:0] exp_bx;  // value B must show during XFER
      logic [7:0] exp_rd;  // rdata at ack
   } vec_t;

   logic       clk = 1'b0;
   logic       _reset = 1'b0;
   logic [7:0] b_drv = 8'h00;

   logic       req1 = 1'b0, we1 = 1'b0;
   logic [7:0] wdata1 = 8'h00;
   logic       ack1, busy1, dir1, n_oe1, a_oe1;
   logic [7:0] rdata1, a_out1, a_in1, a_line1, b_line1;

   logic       req2 = 1'b0, we2 = 1'b0;
   logic [7:0] wdata2 = 8'h00;
   logic       ack2, busy2, dir2, n_oe2, a_oe2;
   logic [7:0] rdata2, a_out2, a_in2, a_line2, b_line2;

   logic [4:0] st1, st2;

   int total = 0;
   int bad = 0;
   logic rst_e = 1'b1;
   logic have_prev = 1'b0;
   logic prev_dir, prev_noe;

   always #5 clk = ~clk;

   hct245_bus_ctrl #(
      .WIDTH(8), .TURN_CYCLES(1), .XFER_CYCLES(2), .NAME("BUS1"), .LOG(0)
   ) dut1 (
      .clk(clk), ._reset(_reset), .req(req1), .we(we1), .wdata(wdata1),
      .ack(ack1), .busy(busy1), .rdata(rdata1), .dir(dir1), .nOE(n_oe1),
      .a_oe(a_oe1), .a_out(a_out1), .a_in(a_in1)
   );

   hct245_bus_ctrl #(
      .WIDTH(8), .TURN_CYCLES(3), .XFER_CYCLES(1), .NAME("BUS2"), .LOG(0)
   ) dut2 (
      .clk(clk), ._reset(_reset), .req(req2), .we(we2), .wdata(wdata2),
      .ack(ack2), .busy(busy2), .rdata(rdata2), .dir(dir2), .nOE(n_oe2),
      .a_oe(a_oe2), .a_out(a_out2), .a_in(a_in2)
   );

   // Transceiver models; an undriven A side reads as 0.
   assign a_line1 = a_oe1 ? a_out1 : ((!n_oe1 && !dir1) ? b_drv : 8'h00);
   assign b_line1 = (!n_oe1 && dir1) ? a_line1 : b_drv;
   assign a_in1   = a_line1;
   assign a_line2 = a_oe2 ? a_out2 : ((!n_oe2 && !dir2) ? b_drv : 8'h00);
   assign b_line2 = (!n_oe2 && dir2) ? a_line2 : b_drv;
   assign a_in2   = a_line2;

   assign st1 = {busy1, n_oe1, dir1, a_oe1, ack1};
   assign st2 = {busy2, n_oe2, dir2, a_oe2, ack2};

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
      end
   endtask

   // Per-cycle safety checks on the default instance.
   task automatic mon_check();
      if (!rst_e && have_prev) begin
         total++;
         if (dir1 !== prev_dir && (n_oe1 !== 1'b1 || prev_noe !== 1'b1)) begin
            bad++;
            $display("FAIL dir_turn: dir %0b->%0b with nOE %0b->%0b", prev_dir, dir1,
                     prev_noe, n_oe1);
         end
      end
      total++;
      if (a_oe1 && !dir1) begin
         bad++;
         $display("FAIL a_contention: a_oe=%0b dir=%0b nOE=%0b", a_oe1, dir1, n_oe1);
      end
      prev_dir  = dir1;
      prev_noe  = n_oe1;
      have_prev = 1'b1;
   endtask

   // Advance one clock; sample outputs on the falling edge.
   task automatic tick();
      @(posedge clk);
      rst_e = !_reset;
      @(negedge clk);
      mon_check();
   endtask

   task automatic run_txn(input vec_t v);
      int tc, xc;
      logic [4:0] st, est;
      logic [7:0] b, rd, eb;
      tc = (v.which != 0) ? 3 : 1;
      xc = (v.which != 0) ? 1 : 2;
      st = (v.which != 0) ? st2 : st1;
      chk("idle_before", 32'(st[4]), 32'd0);
      if (v.which == 0) begin
         req1 = 1'b1; we1 = v.we; wdata1 = v.wd;
      end else begin
         req2 = 1'b1; we2 = v.we; wdata2 = v.wd;
      end
      b_drv = v.bval;
      for (int c = 1; c <= tc + xc + 2; c++) begin
         tick();
         if (c == 1) begin
            // Changes while busy must be ignored.
            if (v.which == 0) begin
               req1 = 1'b0; we1 = ~v.we; wdata1 = ~v.wd;
            end else begin
               req2 = 1'b0; we2 = ~v.we; wdata2 = ~v.wd;
            end
         end
         st = (v.which != 0) ? st2 : st1;
         b  = (v.which != 0) ? b_line2 : b_line1;
         rd = (v.which != 0) ? rdata2 : rdata1;
         est[4] = (c <= tc + xc + 1);
         est[3] = !(c > tc && c <= tc + xc);
         est[2] = v.we;
         est[1] = v.we && (c <= tc + xc);
         est[0] = (c == tc + xc + 1);
         chk("txn_pins", 32'(st), 32'(est));
         eb = (c > tc && c <= tc + xc) ? v.exp_bx : v.bval;
         chk("txn_b", 32'(b), 32'(eb));
         if (est[0]) chk("txn_rdata", 32'(rd), 32'(v.exp_rd));
      end
   endtask

   vec_t       vecs[8];
   vec_t       tail;
   logic [4:0] held_exp[10];

   initial begin
      vecs[0] = '{0, 1'b1, 8'hA5, 8'h00, 8'hA5, 8'h00};
      vecs[1] = '{0, 1'b0, 8'h77, 8'h3C, 8'h3C, 8'h3C};
      vecs[2] = '{0, 1'b1, 8'h5A, 8'h00, 8'h5A, 8'h3C};
      vecs[3] = '{0, 1'b0, 8'h12, 8'hC3, 8'hC3, 8'hC3};
      vecs[4] = '{0, 1'b1, 8'hFF, 8'h81, 8'hFF, 8'hC3};
      vecs[5] = '{0, 1'b0, 8'hEE, 8'h00, 8'h00, 8'h00};
      vecs[6] = '{1, 1'b1, 8'h96, 8'h00, 8'h96, 8'h00};
      vecs[7] = '{1, 1'b0, 8'h00, 8'h4B, 8'h4B, 8'h4B};
      // {busy, nOE, dir, a_oe, ack}: write 11 then read with req held high.
      held_exp = '{5'b11110, 5'b10110, 5'b10110, 5'b11101, 5'b01100,
                   5'b11000, 5'b10000, 5'b10000, 5'b11001, 5'b01000};

      // Reset held with requests pending: everything stays quiet.
      _reset = 1'b0;
      req1 = 1'b1; we1 = 1'b1; wdata1 = 8'hAA;
      req2 = 1'b1; we2 = 1'b1; wdata2 = 8'hAA;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("reset_st1", 32'(st1), 32'(5'b01000));
         chk("reset_st2", 32'(st2), 32'(5'b01000));
         chk("reset_rdata", 32'(rdata1), 32'd0);
      end
      req1 = 1'b0; req2 = 1'b0; _reset = 1'b1;
      tick();
      chk("post_reset_idle", 32'(st1), 32'(5'b01000));

      for (int i = 0; i < 8; i++) run_txn(vecs[i]);

      // Write 11 then read, req held high throughout.
      b_drv = 8'h6E;
      req1 = 1'b1; we1 = 1'b1; wdata1 = 8'h11;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 1) begin we1 = 1'b0; wdata1 = 8'h00; end
         if (c == 6) req1 = 1'b0;
         chk("held_pins", 32'(st1), 32'(held_exp[c-1]));
         if (c == 2 || c == 3) chk("held_b", 32'(b_line1), 32'h11);
         if (c == 9) chk("held_rdata", 32'(rdata1), 32'h6E);
      end

      // Abort a write of FF in XFER.
      b_drv = 8'h00;
      req1 = 1'b1; we1 = 1'b1; wdata1 = 8'hFF;
      tick();
      req1 = 1'b0;
      tick();
      chk("abort_in_xfer", 32'(n_oe1), 32'd0);
      _reset = 1'b0;
      tick();
      chk("abort_pins", 32'(st1), 32'(5'b01000));
      _reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("abort_no_ack", 32'(st1), 32'(5'b01000));
      end
      tail = '{0, 1'b1, 8'h01, 8'h00, 8'h01, 8'h00};
      run_txn(tail);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
